cmps_seq: RTL and testbench
===========================

Name: cmps_seq

Overview:
- Execute-stage sequencer for CMPS and REP/REPE/REPNE CMPS; sits directly upstream of alu1.
- Issues the source read (ESI) then the destination read (EDI), holds the source data on mem_out_latched and presents the destination data on mem_out.
- Samples alu1's cmps_flags, steps ESI/EDI/ECX, and decides REP termination.
- Stalls the pipeline (busy) until the string instruction retires.

Parameters:
- AW, 32, address / pointer width.
- DW, 32, memory read data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  string-compare instruction valid in EX (1-cycle pulse)
- rep  in  1  REP-class prefix present
- repz  in  1  1 = REPE/REPZ, 0 = REPNE/REPNZ (ignored when rep=0)
- op_size  in  2  00 byte, 01 word, 10 dword (11 illegal)
- df  in  1  direction flag: 0 increment, 1 decrement
- esi_in  in  AW  ESI at start
- edi_in  in  AW  EDI at start
- ecx_in  in  32  ECX at start
- mem_rd_req  out  1  read request
- mem_rd_addr  out  AW  read address
- mem_rd_size  out  2  equals latched op_size; drives alu1 mem_rd_size
- mem_rd_ready  in  1  read data valid
- mem_rd_data  in  DW  read data, zero-extended to DW
- mem_out_latched  out  DW  source operand to alu1
- mem_out  out  DW  destination operand to alu1
- cmps_flags  in  6  {OF,SF,ZF,AF,PF,CF} from alu1
- flags_wr  out  1  load all six flags this cycle
- flags_out  out  6  flags to load
- reg_wr  out  1  write ESI/EDI/ECX this cycle
- esi_out  out  AW  final ESI
- edi_out  out  AW  final EDI
- ecx_out  out  32  final ECX
- busy  out  1  stall upstream
- done  out  1  1-cycle retire pulse

Behaviour:
- States: IDLE, RD_SRC, RD_DST, CMP, FIN.
- Reset: synchronous, active-high. State goes to IDLE. All outputs 0. Internal pointer, count and data registers are cleared. An outstanding request is dropped. Reset mid-operation aborts with no reg_wr and no flags_wr.

IDLE:
- busy=0.
- On start:
  - Latch size, df, rep, repz, esi, edi, ecx.
  - If rep=1 and ecx_in=0: go to FIN. No reads and no flags_wr.
  - Otherwise go to RD_SRC.
- busy rises the cycle after start.

RD_SRC:
- Drive mem_rd_req=1 and mem_rd_addr=esi.
- Address and size stay stable until mem_rd_ready is sampled high.
- On ready:
  - mem_out_latched <= mem_rd_data.
  - esi <= esi ± step.
  - Go to RD_DST.
- mem_rd_ready while mem_rd_req=0 is ignored.

RD_DST:
- Same request rules with addr=edi.
- On ready:
  - mem_out <= mem_rd_data.
  - edi <= edi ± step.
  - Go to CMP.
- mem_rd_req deasserts on the cycle after ready. A new request may reassert in the following state.

CMP (exactly 1 cycle):
- mem_out_latched and mem_out are stable, so alu1 computes src − dst combinationally.
- flags_wr=1 and flags_out=cmps_flags.
- If rep=0: go to FIN.
- If rep=1:
  - ecx <= ecx − 1.
  - Terminate if the new ecx=0, or repz=1 and ZF=0, or repz=0 and ZF=1.
  - Terminate → FIN. Otherwise → RD_SRC.

FIN (exactly 1 cycle):
- reg_wr=1 and done=1.
- esi_out, edi_out, ecx_out hold the final values. ecx_out is unchanged when rep=0.
- Go to IDLE.
- busy=1 in RD_SRC, RD_DST, CMP and FIN.

Step arithmetic:
- step = 1 << op_size.
- df=1 subtracts step; df=0 adds step.
- Arithmetic is modulo 2^AW, so wrap-around is silent, e.g. 0x00000000 − 4 = 0xFFFFFFFC.
- ECX decrement wraps likewise, but the 0 check precedes any further iteration.

Other boundary rules:
- op_size=11 behaves as dword.
- start while busy=1 is ignored.
- mem_out and mem_out_latched hold their values after FIN until the next capture.

Decomposition:
- Shared package holds:
  - State encoding constants (CS_IDLE … CS_FIN, 3 bits).
  - Size encodings SZ_BYTE, SZ_WORD, SZ_DWORD.
  - Flag bit indices CF=0, PF=1, AF=2, ZF=3, SF=4, OF=5, matching alu1.
- One natural sub-module: ptr_step, combinational. Inputs ptr, size, df; output ptr ± (1<<size). Instantiated twice, for ESI and EDI.

Test Plan:
- Non-REP byte, df=0, esi=0x100, edi=0x200, src=0x41, dst=0x41, ready latency 1:
  - one flags_wr with ZF=1, CF=0.
  - done with esi_out=0x101, edi_out=0x201.
  - reg_wr also occurs with ecx_out = ecx_in.
- REPE dword, df=1, ecx=3, esi=0x1000, edi=0x2000, data equal on iter 1, unequal on iter 2 (src=5, dst=7):
  - two flags_wr; the last has ZF=0, CF=1.
  - ecx_out=1, esi_out=0xFF8, edi_out=0x1FF8.
- REPNE word, ecx=2, all unequal:
  - runs 2 iterations, ecx_out=0, esi/edi advanced by 4.
- REP with ecx=0:
  - no mem_rd_req, no flags_wr.
  - done and reg_wr 2 cycles after start, with outputs equal to the inputs.
- Variable ready latency (0–5 idle cycles):
  - mem_rd_addr and mem_rd_size stay stable while req is high.
  - A spurious ready while idle changes nothing.
  - esi=0x0 with df=1 and dword size wraps to 0xFFFFFFFC.
- Assert rst during RD_DST:
  - next cycle: state IDLE, mem_rd_req=0, busy=0, no done/reg_wr.
  - a following start executes normally.

Source files
------------

// File: rtl/cmps_seq_pkg.sv
// Shared encodings for the CMPS execute-stage sequencer and its helpers.
package cmps_seq_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_RD_SRC = 3'd1,
        CS_RD_DST = 3'd2,
        CS_CMP    = 3'd3,
        CS_FIN    = 3'd4
    } cs_state_e;

    // Operand size encodings (2'b11 is illegal and treated as dword).
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_WORD  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;

    // Bit positions inside the {OF,SF,ZF,AF,PF,CF} vector produced by alu1.
    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_AF = 2;
    localparam int FLAG_ZF = 3;
    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 5;

    // Fold the illegal size code onto dword so every consumer sees a legal size.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_DWORD : size;
    endfunction

endpackage

// File: rtl/cmps_seq_ptr_step.sv
// Combinational string-pointer stepper: ptr +/- (1 << size), modulo 2^AW.
module ptr_step
    import cmps_seq_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] ptr_i,
    input  logic [1:0]    size_i,
    input  logic          df_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] step;

    // Decode the element size into a byte stride.
    always_comb begin
        // NOTE: default first so every path assigns step and no latch is inferred.
        step = '0;
        case (norm_size(size_i))
            SZ_BYTE: step = AW'(1);
            SZ_WORD: step = AW'(2);
            default: step = AW'(4);
        endcase
    end

    // Direction flag set walks the string downwards; wrap-around is intentional.
    assign ptr_o = df_i ? (ptr_i - step) : (ptr_i + step);

endmodule

// File: rtl/cmps_seq.sv
// CMPS / REP CMPS execute-stage sequencer feeding alu1: reads source then
// destination, samples the compare flags, steps ESI/EDI/ECX and retires.
module cmps_seq
    import cmps_seq_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rep,
    input  logic          repz,
    input  logic [1:0]    op_size,
    input  logic          df,
    input  logic [AW-1:0] esi_in,
    input  logic [AW-1:0] edi_in,
    input  logic [31:0]   ecx_in,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_rd_addr,
    output logic [1:0]    mem_rd_size,
    input  logic          mem_rd_ready,
    input  logic [DW-1:0] mem_rd_data,
    output logic [DW-1:0] mem_out_latched,
    output logic [DW-1:0] mem_out,
    input  logic [5:0]    cmps_flags,
    output logic          flags_wr,
    output logic [5:0]    flags_out,
    output logic          reg_wr,
    output logic [AW-1:0] esi_out,
    output logic [AW-1:0] edi_out,
    output logic [31:0]   ecx_out,
    output logic          busy,
    output logic          done
);

    cs_state_e     state_q;
    logic [1:0]    size_q;
    logic          df_q;
    logic          rep_q;
    logic          repz_q;
    logic [AW-1:0] esi_q;
    logic [AW-1:0] edi_q;
    logic [31:0]   ecx_q;
    logic [DW-1:0] src_q;
    logic [DW-1:0] dst_q;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          done_q;
    logic          reg_wr_q;
    logic          flags_wr_q;

    logic [AW-1:0] esi_d;
    logic [AW-1:0] edi_d;
    logic [31:0]   ecx_d;
    logic          zf;
    logic          rep_stop;

    ptr_step #(.AW(AW)) u_esi_step (
        .ptr_i  (esi_q),
        .size_i (size_q),
        .df_i   (df_q),
        .ptr_o  (esi_d)
    );

    ptr_step #(.AW(AW)) u_edi_step (
        .ptr_i  (edi_q),
        .size_i (size_q),
        .df_i   (df_q),
        .ptr_o  (edi_d)
    );

    // REP termination: count exhausted, or the ZF condition of REPE/REPNE fails.
    assign ecx_d    = ecx_q - 32'd1;
    assign zf       = cmps_flags[FLAG_ZF];
    assign rep_stop = (ecx_d == 32'd0) || (repz_q ? !zf : zf);

    // Sequencer FSM with registered strobes, request and address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CS_IDLE;
            size_q     <= '0;
            df_q       <= 1'b0;
            rep_q      <= 1'b0;
            repz_q     <= 1'b0;
            esi_q      <= '0;
            edi_q      <= '0;
            ecx_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            reg_wr_q   <= 1'b0;
            flags_wr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register updates from pre-edge values.
            done_q     <= 1'b0;
            reg_wr_q   <= 1'b0;
            flags_wr_q <= 1'b0;
            case (state_q)
                CS_IDLE: begin
                    if (start) begin
                        size_q <= norm_size(op_size);
                        df_q   <= df;
                        rep_q  <= rep;
                        repz_q <= repz;
                        esi_q  <= esi_in;
                        edi_q  <= edi_in;
                        ecx_q  <= ecx_in;
                        busy_q <= 1'b1;
                        if (rep && (ecx_in == 32'd0)) begin
                            state_q  <= CS_FIN;
                            done_q   <= 1'b1;
                            reg_wr_q <= 1'b1;
                        end else begin
                            state_q <= CS_RD_SRC;
                            req_q   <= 1'b1;
                            addr_q  <= esi_in;
                        end
                    end
                end
                CS_RD_SRC: begin
                    if (mem_rd_ready) begin
                        src_q   <= mem_rd_data;
                        esi_q   <= esi_d;
                        addr_q  <= edi_q;
                        state_q <= CS_RD_DST;
                    end
                end
                CS_RD_DST: begin
                    if (mem_rd_ready) begin
                        dst_q      <= mem_rd_data;
                        edi_q      <= edi_d;
                        req_q      <= 1'b0;
                        flags_wr_q <= 1'b1;
                        state_q    <= CS_CMP;
                    end
                end
                CS_CMP: begin
                    if (rep_q && !rep_stop) begin
                        ecx_q   <= ecx_d;
                        req_q   <= 1'b1;
                        addr_q  <= esi_q;
                        state_q <= CS_RD_SRC;
                    end else begin
                        if (rep_q) begin
                            ecx_q <= ecx_d;
                        end
                        done_q   <= 1'b1;
                        reg_wr_q <= 1'b1;
                        state_q  <= CS_FIN;
                    end
                end
                CS_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= CS_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= CS_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_req      = req_q;
    assign mem_rd_addr     = addr_q;
    assign mem_rd_size     = size_q;
    assign mem_out_latched = src_q;
    assign mem_out         = dst_q;
    // alu1 evaluates src - dst combinationally during CMP; pass its flags through.
    assign flags_wr        = flags_wr_q;
    assign flags_out       = flags_wr_q ? cmps_flags : 6'd0;
    assign reg_wr          = reg_wr_q;
    assign esi_out         = esi_q;
    assign edi_out         = edi_q;
    assign ecx_out         = ecx_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_cmps_seq.sv
// Scoreboard bench for cmps_seq with an alu1 compare model and a memory responder.
module tb_cmps_seq;
    import cmps_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rep;
    logic        repz;
    logic [1:0]  op_size;
    logic        df;
    logic [31:0] esi_in;
    logic [31:0] edi_in;
    logic [31:0] ecx_in;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [1:0]  mem_rd_size;
    logic        mem_rd_ready;
    logic [31:0] mem_rd_data;
    logic [31:0] mem_out_latched;
    logic [31:0] mem_out;
    logic [5:0]  cmps_flags;
    logic        flags_wr;
    logic [5:0]  flags_out;
    logic        reg_wr;
    logic [31:0] esi_out;
    logic [31:0] edi_out;
    logic [31:0] ecx_out;
    logic        busy;
    logic        done;

    cmps_seq #(.AW(32), .DW(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .rep             (rep),
        .repz            (repz),
        .op_size         (op_size),
        .df              (df),
        .esi_in          (esi_in),
        .edi_in          (edi_in),
        .ecx_in          (ecx_in),
        .mem_rd_req      (mem_rd_req),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_size     (mem_rd_size),
        .mem_rd_ready    (mem_rd_ready),
        .mem_rd_data     (mem_rd_data),
        .mem_out_latched (mem_out_latched),
        .mem_out         (mem_out),
        .cmps_flags      (cmps_flags),
        .flags_wr        (flags_wr),
        .flags_out       (flags_out),
        .reg_wr          (reg_wr),
        .esi_out         (esi_out),
        .edi_out         (edi_out),
        .ecx_out         (ecx_out),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        zf;
        logic        cf;
        logic [31:0] src;
        logic [31:0] dst;
    } flag_exp_t;

    typedef struct {
        logic [31:0] esi;
        logic [31:0] edi;
        logic [31:0] ecx;
    } done_exp_t;

    flag_exp_t   fq[$];
    done_exp_t   dq[$];
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_seen  = 0;
    int done_base  = 0;
    int done_cyc   = 0;
    int start_cyc  = 0;
    int req_cycles = 0;
    int flg_cycles = 0;
    int lat  = 0;
    logic spur = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // alu1 model: src - dst at the operand size -> {OF,SF,ZF,AF,PF,CF}.
    function automatic logic [5:0] alu_cmp(input logic [31:0] s, input logic [31:0] d,
                                           input logic [1:0] sz);
        logic [31:0] a, b, r;
        logic [7:0]  lo;
        logic [5:0]  f;
        int          sh;
        sh = (sz == SZ_BYTE) ? 24 : (sz == SZ_WORD) ? 16 : 0;
        a  = s << sh;
        b  = d << sh;
        r  = a - b;
        lo = s[7:0] - d[7:0];
        f  = '0;
        f[FLAG_CF] = (a < b);
        f[FLAG_PF] = ~^lo;
        f[FLAG_AF] = (s[3:0] < d[3:0]);
        f[FLAG_ZF] = (r == 32'd0);
        f[FLAG_SF] = r[31];
        f[FLAG_OF] = (a[31] != b[31]) && (r[31] != a[31]);
        return f;
    endfunction

    always_comb cmps_flags = alu_cmp(mem_out_latched, mem_out, mem_rd_size);

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: lat idle cycles, then a one-cycle ready; optional spurious ready.
    initial begin
        int wait_cnt;
        wait_cnt     = 0;
        mem_rd_ready = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_rd_ready = 1'b0;
                wait_cnt     = lat;
            end else if (mem_rd_ready) begin
                mem_rd_ready = 1'b0;
                wait_cnt     = lat;
            end else if (mem_rd_req) begin
                if (wait_cnt == 0) begin
                    mem_rd_ready = 1'b1;
                    mem_rd_data  = mem.exists(mem_rd_addr) ? mem[mem_rd_addr] : 32'd0;
                end else begin
                    wait_cnt--;
                end
            end else if (spur) begin
                mem_rd_ready = 1'b1;
                mem_rd_data  = 32'hDEAD_BEEF;
                spur         = 1'b0;
            end else begin
                wait_cnt = lat;
            end
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT strobes flags or retires.
    initial begin
        flag_exp_t fe;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_rd_req) req_cycles++;
                if (flags_wr) begin
                    flg_cycles++;
                    check("flags_wr_expected", 32'(fq.size() != 0), 32'd1);
                    if (fq.size() != 0) begin
                        fe = fq.pop_front();
                        check("flags_zf", 32'(flags_out[FLAG_ZF]), 32'(fe.zf));
                        check("flags_cf", 32'(flags_out[FLAG_CF]), 32'(fe.cf));
                        check("cmp_src", mem_out_latched, fe.src);
                        check("cmp_dst", mem_out, fe.dst);
                    end
                end
                if (done) begin
                    done_seen++;
                    done_cyc = cyc;
                    check("reg_wr_with_done", 32'(reg_wr), 32'd1);
                    check("done_expected", 32'(dq.size() != 0), 32'd1);
                    if (dq.size() != 0) begin
                        de = dq.pop_front();
                        check("esi_out", esi_out, de.esi);
                        check("edi_out", edi_out, de.edi);
                        check("ecx_out", ecx_out, de.ecx);
                    end
                end
            end
        end
    end

    // Request stability: with req held and no ready taken, addr and size must not move.
    initial begin
        logic        p_req;
        logic [31:0] p_addr;
        logic [1:0]  p_size;
        p_req = 1'b0;
        p_addr = '0;
        p_size = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                p_req = 1'b0;
            end else begin
                if (p_req && !mem_rd_ready && mem_rd_req) begin
                    check("rd_addr_stable", mem_rd_addr, p_addr);
                    check("rd_size_stable", 32'(mem_rd_size), 32'(p_size));
                end
                p_req  = mem_rd_req;
                p_addr = mem_rd_addr;
                p_size = mem_rd_size;
            end
        end
    end

    task automatic push_flags(input logic zf, input logic cf, input logic [31:0] s, input logic [31:0] d);
        flag_exp_t e;
        e.zf = zf; e.cf = cf; e.src = s; e.dst = d;
        fq.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] esi, input logic [31:0] edi, input logic [31:0] ecx);
        done_exp_t e;
        e.esi = esi; e.edi = edi; e.ecx = ecx;
        dq.push_back(e);
    endtask

    task automatic start_op(input logic [1:0] sz, input logic d, input logic r, input logic rz,
                            input logic [31:0] esi, input logic [31:0] edi, input logic [31:0] ecx);
        @(negedge clk);
        done_base = done_seen;
        op_size   = sz;
        df        = d;
        rep       = r;
        repz      = rz;
        esi_in    = esi;
        edi_in    = edi;
        ecx_in    = ecx;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && done_seen == done_base; i++) @(posedge clk);
        check(name, 32'(done_seen != done_base), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int r0, f0, found;
        rst = 1'b1; start = 1'b0; rep = 1'b0; repz = 1'b0; op_size = '0; df = 1'b0;
        esi_in = '0; edi_in = '0; ecx_in = '0;
        mem[32'h100]  = 32'h41;       mem[32'h200]  = 32'h41;
        mem[32'h1000] = 32'h1234;     mem[32'h2000] = 32'h1234;
        mem[32'hFFC]  = 32'd5;        mem[32'h1FFC] = 32'd7;
        mem[32'h300]  = 32'h10;       mem[32'h400]  = 32'h20;
        mem[32'h302]  = 32'h30;       mem[32'h402]  = 32'h31;
        mem[32'h0]    = 32'h8000_0000; mem[32'h20]  = 32'd1;
        mem[32'h50]   = 32'h01;       mem[32'h60]   = 32'h02;
        mem[32'h700]  = 32'h99;       mem[32'h800]  = 32'h99;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mem_rd_req), 32'd0);
        check("rst_done_regwr", {30'd0, done, reg_wr}, 32'd0);
        check("rst_flags_wr", 32'(flags_wr), 32'd0);
        check("rst_mem_out", mem_out, 32'd0);
        check("rst_src", mem_out_latched, 32'd0);

        // Non-REP byte, equal operands.
        lat = 0;
        push_flags(1'b1, 1'b0, 32'h41, 32'h41);
        push_done(32'h101, 32'h201, 32'h55);
        start_op(SZ_BYTE, 1'b0, 1'b0, 1'b0, 32'h100, 32'h200, 32'h55);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done("t1_done");

        // REPE dword, df=1: equal then unequal, ignored start while busy.
        lat = 1;
        push_flags(1'b1, 1'b0, 32'h1234, 32'h1234);
        push_flags(1'b0, 1'b1, 32'd5, 32'd7);
        push_done(32'hFF8, 32'h1FF8, 32'd1);
        start_op(SZ_DWORD, 1'b1, 1'b1, 1'b1, 32'h1000, 32'h2000, 32'd3);
        @(negedge clk);
        esi_in = 32'hBAD0; edi_in = 32'hBAD4; ecx_in = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t2_done");

        // REPNE word, all unequal: runs until ECX reaches zero.
        lat = 2;
        push_flags(1'b0, 1'b1, 32'h10, 32'h20);
        push_flags(1'b0, 1'b1, 32'h30, 32'h31);
        push_done(32'h304, 32'h404, 32'd0);
        start_op(SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h300, 32'h400, 32'd2);
        wait_done("t3_done");

        // REP with ECX=0: no reads, no flags, fast retire.
        r0 = req_cycles; f0 = flg_cycles;
        push_done(32'h500, 32'h600, 32'd0);
        start_op(SZ_DWORD, 1'b0, 1'b1, 1'b1, 32'h500, 32'h600, 32'd0);
        wait_done("t4_done");
        check("t4_no_req", 32'(req_cycles - r0), 32'd0);
        check("t4_no_flags", 32'(flg_cycles - f0), 32'd0);
        check("t4_latency_ok", 32'((done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)), 32'd1);

        // Spurious ready while idle; operand registers must hold the last capture.
        spur = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_req", 32'(mem_rd_req), 32'd0);
        check("hold_src", mem_out_latched, 32'h30);
        check("hold_dst", mem_out, 32'h31);

        // Non-REP dword df=1 from ESI=0 with long latency: ESI wraps.
        lat = 5;
        push_flags(1'b0, 1'b0, 32'h8000_0000, 32'd1);
        push_done(32'hFFFF_FFFC, 32'h1C, 32'd7);
        start_op(2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'd7);
        check("size11_as_dword", 32'(mem_rd_size), 32'(SZ_DWORD));
        wait_done("t5_done");

        // Non-REP byte df=1, zero latency, src < dst.
        lat = 0;
        push_flags(1'b0, 1'b1, 32'h01, 32'h02);
        push_done(32'h4F, 32'h5F, 32'd3);
        start_op(SZ_BYTE, 1'b1, 1'b0, 1'b0, 32'h50, 32'h60, 32'd3);
        wait_done("t6_done");

        // Reset while the destination read is outstanding.
        lat = 3;
        start_op(SZ_DWORD, 1'b0, 1'b1, 1'b1, 32'h700, 32'h800, 32'd5);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (mem_rd_req && mem_rd_addr == 32'h800) found = 1;
        end
        check("t7_reached_rd_dst", 32'(found), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_req", 32'(mem_rd_req), 32'd0);
        check("t7_done_regwr", {30'd0, done, reg_wr}, 32'd0);
        check("t7_flags_wr", 32'(flags_wr), 32'd0);
        check("t7_src_cleared", mem_out_latched, 32'd0);
        repeat (2) @(negedge clk);

        // Normal operation after the abort.
        lat = 2;
        push_flags(1'b1, 1'b0, 32'h41, 32'h41);
        push_done(32'h101, 32'h201, 32'h66);
        start_op(SZ_BYTE, 1'b0, 1'b0, 1'b0, 32'h100, 32'h200, 32'h66);
        wait_done("t8_done");

        repeat (5) @(negedge clk);
        check("flags_queue_empty", 32'(fq.size()), 32'd0);
        check("done_queue_empty", 32'(dq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
